// File: rtl/regwrite_buffer_if.sv
// Request, drain and bypass-lookup signals of the register write-back buffer.
// The master modport is the surrounding pipeline; the slave modport is the buffer.
interface regwrite_buffer_if #(
  parameter int PTR_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_rd;
  logic [15:0]      in_data;
  logic             drain_en;
  logic             RegWrite;
  logic [2:0]       RD;
  logic [15:0]      WriteData;
  logic [2:0]       RS;
  logic [2:0]       RT;
  logic             hit_rs;
  logic             hit_rt;
  logic [15:0]      fwd_rs;
  logic [15:0]      fwd_rt;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;

  modport master (
    output in_valid, in_rd, in_data, drain_en, RS, RT,
    input  in_ready, RegWrite, RD, WriteData, hit_rs, hit_rt, fwd_rs, fwd_rt,
           count, empty, full
  );

  modport slave (
    input  in_valid, in_rd, in_data, drain_en, RS, RT,
    output in_ready, RegWrite, RD, WriteData, hit_rs, hit_rt, fwd_rs, fwd_rt,
           count, empty, full
  );
endinterface

// File: rtl/regwrite_buffer.sv
// FIFO of pending register-file writes, drained one per enabled cycle, with a
// combinational youngest-match bypass for the two operand read indices.
module regwrite_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  regwrite_buffer_if.slave    bus
);

  logic [15:0]      data_q [DEPTH];
  logic [15:0]      data_d [DEPTH];
  logic [2:0]       rd_q   [DEPTH];
  logic [2:0]       rd_d   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full, empty, push, pop;
  logic             hit_rs, hit_rt;
  logic [15:0]      fwd_rs, fwd_rt;
  logic [PTR_W-1:0] idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.drain_en;

  assign bus.in_ready  = !full;
  assign bus.RegWrite  = pop;
  assign bus.RD        = rd_q[rd_ptr_q];
  assign bus.WriteData = data_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.hit_rs    = hit_rs;
  assign bus.hit_rt    = hit_rt;
  assign bus.fwd_rs    = fwd_rs;
  assign bus.fwd_rt    = fwd_rt;

  always_comb begin
    data_d   = data_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Push and pop never hit the same slot: that needs full or empty, both excluded.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      data_d[wr_ptr_q]  = bus.in_data;
      rd_d[wr_ptr_q]    = bus.in_rd;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest from the head so the last match wins.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    fwd_rs = '0;
    fwd_rt = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[idx] && rd_q[idx] == bus.RS) begin
        hit_rs = 1'b1;
        fwd_rs = data_q[idx];
      end
      if (valid_q[idx] && rd_q[idx] == bus.RT) begin
        hit_rt = 1'b1;
        fwd_rt = data_q[idx];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge Clock) begin
    data_q <= data_d;
    rd_q   <= rd_d;
  end

endmodule
